// File: rtl/uart_bus_pkg.sv
// Shared constants and state encoding for the UART-to-memory-bus initiator.
package uart_bus_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP,
        S_CMD_ERR
    } state_t;

endpackage

// File: rtl/uart_bus_master_frame_timeout.sv
// Inter-byte idle counter: saturates at TIMEOUT_CYCLES and flags expiry until cleared.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/uart_bus_master.sv
// Decodes write/read frames from a byte stream and runs single 32-bit bus accesses,
// returning an ack, the read data, or an error byte over the transmit channel.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        busy,
    output logic        drop
);

    state_t      state_reg, state_next;
    logic        is_write_reg, is_write_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] addr_sh_reg, addr_sh_next;
    logic [31:0] data_sh_reg, data_sh_next;
    logic [31:0] resp_sh_reg, resp_sh_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        busy_reg;
    logic        to_enable, to_clear, to_expired;

    // Idle time only counts while a frame is being collected.
    assign to_enable = (state_reg == S_ADDR) || (state_reg == S_DATA);
    assign to_clear  = rx_valid || !to_enable;

    frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (to_enable),
        .clear   (to_clear),
        .expired (to_expired)
    );

    always_comb begin
        state_next     = state_reg;
        is_write_next  = is_write_reg;
        cnt_next       = cnt_reg;
        addr_sh_next   = addr_sh_reg;
        data_sh_next   = data_sh_reg;
        resp_sh_next   = resp_sh_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_next = 2'd0;
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_next    = S_ADDR;
                        is_write_next = (rx_data == CMD_WR);
                    end else begin
                        state_next = S_CMD_ERR;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_sh_next = {addr_sh_reg[23:0], rx_data};
                    cnt_next     = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        if (is_write_reg) begin
                            state_next = S_DATA;
                        end else begin
                            state_next    = S_RD_REQ;
                            mem_addr_next = {addr_sh_next[31:2], 2'b00};
                        end
                    end
                end else if (to_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_sh_next = {data_sh_reg[23:0], rx_data};
                    cnt_next     = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_next     = S_WR_REQ;
                        mem_addr_next  = {addr_sh_reg[31:2], 2'b00};
                        mem_wdata_next = data_sh_next;
                    end
                end else if (to_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_WR_REQ: state_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (!mem_wbusy) begin
                    state_next   = S_RESP;
                    resp_sh_next = {RSP_OK, 24'h0};
                    cnt_next     = 2'd0;
                end
            end
            S_RD_REQ: state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (!mem_rbusy) begin
                    state_next   = S_RESP;
                    resp_sh_next = mem_rdata;
                    cnt_next     = 2'd3;
                end
            end
            S_CMD_ERR: begin
                state_next   = S_RESP;
                resp_sh_next = {RSP_ERR, 24'h0};
                cnt_next     = 2'd0;
            end
            S_RESP: begin
                // cnt_reg holds the number of bytes still to follow the current one.
                if (tx_ready) begin
                    if (cnt_reg == 2'd0) begin
                        state_next = S_IDLE;
                    end else begin
                        resp_sh_next = {resp_sh_reg[23:0], 8'h00};
                        cnt_next     = cnt_reg - 2'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            is_write_reg  <= 1'b0;
            cnt_reg       <= 2'd0;
            addr_sh_reg   <= '0;
            data_sh_reg   <= '0;
            resp_sh_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            is_write_reg  <= is_write_next;
            cnt_reg       <= cnt_next;
            addr_sh_reg   <= addr_sh_next;
            data_sh_reg   <= data_sh_next;
            resp_sh_reg   <= resp_sh_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = {4{state_reg == S_WR_REQ}};
    assign mem_rstrb = (state_reg == S_RD_REQ);
    assign tx_data   = resp_sh_reg[31:24];
    assign tx_valid  = (state_reg == S_RESP);
    assign busy      = busy_reg;
    assign drop      = rx_valid && (state_reg inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ,
                                                     S_RD_WAIT, S_RESP, S_CMD_ERR});

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master against a one-cycle-latency RAM model.
module tb_uart_bus_master;
    import uart_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        mem_rbusy = 1'b0;
    logic        mem_wbusy = 1'b0;
    logic        busy, drop;

    logic [31:0] ram [0:255];
    logic [31:0] ram_rdata;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    int passed = 0;
    int total  = 0;

    int          wmask_cnt = 0, rstrb_cnt = 0, drop_cnt = 0, tx_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;
    logic [7:0]  tx_log [0:255];

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wmask == 4'hF) ram[mem_addr[9:2]] <= mem_wdata;
        if (mem_rstrb) ram_rdata <= ram[mem_addr[9:2]];
    end
    assign mem_rdata = ovr_en ? ovr_val : ram_rdata;

    // Observe bus and tx activity mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wmask != 4'h0) begin
                wmask_cnt  <= wmask_cnt + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end
            if (mem_rstrb) begin
                rstrb_cnt  <= rstrb_cnt + 1;
                last_raddr <= mem_addr;
            end
            if (tx_valid && tx_ready) begin
                tx_log[tx_cnt[7:0]] <= tx_data;
                tx_cnt <= tx_cnt + 1;
            end
            if (drop) drop_cnt <= drop_cnt + 1;
        end
    end

    function automatic logic [31:0] get4(input int t0);
        return {tx_log[t0[7:0]], tx_log[8'(t0 + 1)], tx_log[8'(t0 + 2)], tx_log[8'(t0 + 3)]};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(CMD_RD);
        send_byte(a[31:24]); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(CMD_WR);
        send_byte(a[31:24]); send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_cnt < n && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (tx_cnt >= n) passed++;
        else $display("FAIL wait_tx: got %0d bytes, want %0d", tx_cnt, n);
    endtask

    task automatic test_reset;
        total++;
        if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_addr_data: got %h want 0", {mem_addr, mem_wdata});
        else passed++;
        total++;
        if ({mem_wmask, mem_rstrb, tx_valid, busy, drop} !== 8'h0)
            $display("FAIL reset_ctrl: got %b want 0", {mem_wmask, mem_rstrb, tx_valid, busy, drop});
        else passed++;
        total++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data);
        else passed++;
    endtask

    task automatic test_write;
        int t0 = tx_cnt;
        int w0 = wmask_cnt;
        send_byte(CMD_WR);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy); else passed++;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_tx(t0 + 1);
        total++;
        if (tx_log[t0[7:0]] !== 8'h4B) $display("FAIL write_resp: got %h want 4b", tx_log[t0[7:0]]); else passed++;
        total++;
        if (wmask_cnt - w0 != 1) $display("FAIL write_pulses: got %0d want 1", wmask_cnt - w0); else passed++;
        total++;
        if (last_waddr !== 32'h100) $display("FAIL write_addr: got %h want 00000100", last_waddr); else passed++;
        total++;
        if (last_wdata !== 32'hDEADBEEF) $display("FAIL write_data: got %h want deadbeef", last_wdata); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL write_busy_fall: got %b want 0", busy); else passed++;
    endtask

    task automatic test_read;
        int t0 = tx_cnt;
        int r0 = rstrb_cnt;
        send_read(32'h100);
        wait_tx(t0 + 4);
        total++;
        if (rstrb_cnt - r0 != 1) $display("FAIL read_pulses: got %0d want 1", rstrb_cnt - r0); else passed++;
        total++;
        if (last_raddr !== 32'h100) $display("FAIL read_addr: got %h want 00000100", last_raddr); else passed++;
        total++;
        if (get4(t0) !== 32'hDEADBEEF) $display("FAIL read_resp: got %h want deadbeef", get4(t0)); else passed++;
    endtask

    task automatic test_unaligned;
        int t0 = tx_cnt;
        send_read(32'h00400007);
        wait_tx(t0 + 4);
        total++;
        if (last_raddr !== 32'h00400004) $display("FAIL unaligned_addr: got %h want 00400004", last_raddr); else passed++;
    endtask

    task automatic test_unknown;
        int t0 = tx_cnt;
        int w0 = wmask_cnt;
        int r0 = rstrb_cnt;
        send_byte(8'h41);
        wait_tx(t0 + 1);
        total++;
        if (tx_log[t0[7:0]] !== 8'h3F) $display("FAIL unknown_resp: got %h want 3f", tx_log[t0[7:0]]); else passed++;
        total++;
        if (wmask_cnt != w0 || rstrb_cnt != r0)
            $display("FAIL unknown_bus: got %0d strobes want 0", (wmask_cnt - w0) + (rstrb_cnt - r0));
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL unknown_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_wbusy;
        int t0 = tx_cnt;
        send_write(32'h8, 32'h11223344);
        mem_wbusy = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (tx_cnt != t0) $display("FAIL wbusy_early: got %0d bytes want 0", tx_cnt - t0); else passed++;
        mem_wbusy = 1'b0;
        wait_tx(t0 + 1);
        total++;
        if (tx_log[t0[7:0]] !== 8'h4B) $display("FAIL wbusy_resp: got %h want 4b", tx_log[t0[7:0]]); else passed++;
        total++;
        if (last_wdata !== 32'h11223344) $display("FAIL wbusy_wdata: got %h want 11223344", last_wdata); else passed++;
    endtask

    task automatic test_rbusy;
        int t0 = tx_cnt;
        ovr_en  = 1'b1;
        ovr_val = 32'hBAD0BAD0;
        send_read(32'h8);
        mem_rbusy = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (tx_cnt != t0) $display("FAIL rbusy_early: got %0d bytes want 0", tx_cnt - t0); else passed++;
        mem_rbusy = 1'b0;
        ovr_val   = 32'hCAFEF00D;
        wait_tx(t0 + 4);
        ovr_en = 1'b0;
        total++;
        if (get4(t0) !== 32'hCAFEF00D) $display("FAIL rbusy_resp: got %h want cafef00d", get4(t0)); else passed++;
    endtask

    task automatic test_timeout;
        int t0 = tx_cnt;
        int w0 = wmask_cnt;
        int r0 = rstrb_cnt;
        send_byte(CMD_WR); send_byte(8'h00); send_byte(8'h00);
        repeat (5) begin @(posedge clk); #1; end
        total++;
        if (busy !== 1'b1) $display("FAIL timeout_early: got busy %b want 1", busy); else passed++;
        repeat (15) begin @(posedge clk); #1; end
        total++;
        if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else passed++;
        total++;
        if (tx_cnt != t0 || wmask_cnt != w0 || rstrb_cnt != r0)
            $display("FAIL timeout_quiet: got %0d events want 0", (tx_cnt - t0) + (wmask_cnt - w0) + (rstrb_cnt - r0));
        else passed++;
        send_read(32'h100);
        wait_tx(t0 + 4);
        total++;
        if (get4(t0) !== 32'hDEADBEEF) $display("FAIL timeout_next: got %h want deadbeef", get4(t0)); else passed++;
    endtask

    task automatic test_backpressure;
        int t0 = tx_cnt;
        int d0 = drop_cnt;
        int k = 0;
        logic [7:0] first;
        logic stable = 1'b1;
        tx_ready = 1'b0;
        send_read(32'h100);
        while (!tx_valid && k < 20) begin @(posedge clk); #1; k++; end
        first = tx_data;
        repeat (5) begin
            @(posedge clk); #1;
            if (tx_data !== first || tx_valid !== 1'b1) stable = 1'b0;
        end
        send_byte(8'h52);
        if (tx_data !== first || tx_valid !== 1'b1) stable = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (tx_data !== first || tx_valid !== 1'b1) stable = 1'b0;
        end
        total++;
        if (first !== 8'hDE) $display("FAIL bp_first: got %h want de", first); else passed++;
        total++;
        if (stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", stable); else passed++;
        total++;
        if (drop_cnt - d0 != 1) $display("FAIL bp_drop: got %0d want 1", drop_cnt - d0); else passed++;
        tx_ready = 1'b1;
        wait_tx(t0 + 4);
        total++;
        if (get4(t0) !== 32'hDEADBEEF) $display("FAIL bp_resp: got %h want deadbeef", get4(t0)); else passed++;
    endtask

    task automatic test_reset_mid;
        int t0;
        int w0 = wmask_cnt;
        send_byte(CMD_WR);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_rstrb, tx_data, tx_valid, busy, drop} !== 80'h0)
            $display("FAIL reset_mid: got %h want 0",
                     {mem_addr, mem_wdata, mem_wmask, mem_rstrb, tx_data, tx_valid, busy, drop});
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        t0 = tx_cnt;
        send_read(32'h100);
        wait_tx(t0 + 4);
        total++;
        if (wmask_cnt != w0) $display("FAIL reset_mid_write: got %0d writes want 0", wmask_cnt - w0); else passed++;
        total++;
        if (get4(t0) !== 32'hDEADBEEF) $display("FAIL reset_mid_next: got %h want deadbeef", get4(t0)); else passed++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_write;
        test_read;
        test_unaligned;
        test_unknown;
        test_wbusy;
        test_rbusy;
        test_timeout;
        test_backpressure;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
